// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge channel between the fetch unit and the I-memory/cache.
interface if_fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [XLEN-1:0] data;

    modport master (output req, addr, input  ack, data);
    modport slave  (input  req, addr, output ack, data);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one I-memory request at a time and
// presents the fetched word plus PC+4 to IF/ID, with stall, redirect and drain support.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic                   HD_i,
    input  logic                   mem_stall_i,
    input  logic                   branch_i,
    input  logic [31:0]            branch_addr_i,
    input  logic                   jump_i,
    input  logic [31:0]            jump_addr_i,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            instr_o,
    output logic [31:0]            pc4_o,
    output logic                   if_stall_o
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] ibuf_q, ibuf_d;
    logic [XLEN-1:0] ipc4_q, ipc4_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] instr_d, pc4_d;
    logic            stall_d;

    logic            ack_v;
    logic            redirect;
    logic            consume;
    logic [XLEN-1:0] sel_target;
    logic [XLEN-1:0] target;

    // An ack only counts while our request is actually on the bus.
    assign ack_v      = imem.ack & req_q;
    assign redirect   = (branch_i | jump_i) & ~HD_i & ~mem_stall_i;
    assign consume    = (state_q == S_HOLD) & ~HD_i & ~mem_stall_i;
    assign sel_target = branch_i ? branch_addr_i : jump_addr_i;
    assign target     = {sel_target[XLEN-1:2], 2'b00};

    assign imem.req   = req_q;
    assign imem.addr  = req_addr_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        ibuf_d     = ibuf_q;
        ipc4_d     = ipc4_q;

        case (state_q)
            S_FETCH: begin
                if (ack_v && !redirect) begin
                    ibuf_d  = imem.data;
                    ipc4_d  = req_addr_q + XLEN'(4);
                    state_d = S_HOLD;
                end else if (ack_v) begin
                    pc_d       = target;
                    req_addr_d = target;
                end else if (redirect) begin
                    pc_d    = target;
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d       = target;
                    req_addr_d = target;
                    state_d    = S_FETCH;
                end else if (consume) begin
                    pc_d       = ipc4_q;
                    req_addr_d = ipc4_q;
                    state_d    = S_FETCH;
                end
            end
            S_DRAIN: begin
                // A redirect landing on the ack cycle is the latest target and wins.
                if (redirect) begin
                    pc_d = target;
                end
                if (ack_v) begin
                    req_addr_d = redirect ? target : pc_q;
                    state_d    = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        req_d   = (state_d != S_HOLD);
        stall_d = (state_d != S_HOLD);
        instr_d = (state_d == S_HOLD) ? ibuf_d : NOP_INSTR;
        pc4_d   = (state_d == S_HOLD) ? ipc4_d : '0;
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            ibuf_q     <= '0;
            ipc4_q     <= '0;
            req_q      <= 1'b0;
            instr_o    <= NOP_INSTR;
            pc4_o      <= '0;
            if_stall_o <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            ibuf_q     <= ibuf_d;
            ipc4_q     <= ipc4_d;
            req_q      <= req_d;
            instr_o    <= instr_d;
            pc4_o      <= pc4_d;
            if_stall_o <= stall_d;
        end
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues one request at a time to the instruction memory/cache over a req/ack handshake.
- Presents one fetched instruction plus PC+4 to IF/ID.
- Honours hazard and data-memory stalls, and redirects on branch/jump resolved in ID. An in-flight fetch that has been superseded is drained and discarded.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction driven to IF/ID when no valid fetch is held.

Ports:
- clk  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- HD_i  in  1  hazard-detection stall; hold current instruction.
- mem_stall_i  in  1  data-memory stall; hold current instruction.
- branch_i  in  1  taken branch resolved in ID.
- branch_addr_i  in  32  branch target.
- jump_i  in  1  jump resolved in ID.
- jump_addr_i  in  32  jump target.
- imem_req_o  out  1  instruction-memory request.
- imem_addr_o  out  32  request address, word aligned.
- imem_ack_i  in  1  memory has data for the current request.
- imem_data_i  in  32  instruction word, valid when imem_ack_i=1.
- instr_o  out  32  instruction to IF/ID.
- pc4_o  out  32  address of instr_o + 4, to IF/ID.
- if_stall_o  out  1  no valid instruction this cycle; IF/ID inserts a bubble.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - pc=RESET_PC, state=FETCH, req_addr=RESET_PC.
  - Buffer cleared; outputs imem_req_o=0, instr_o=NOP_INSTR, pc4_o=0, if_stall_o=1.
  - The first request is issued in the first cycle after rst_i rises.
  - Reset mid-transaction abandons the request; the memory is reset by the same rst_i.
- Registers:
  - pc: next address to fetch.
  - req_addr: address of the outstanding request.
  - ibuf/ipc4: held instruction and its PC+4.
  - state ∈ {FETCH, HOLD, DRAIN}.
- Handshake:
  - imem_req_o=1 in FETCH and DRAIN; imem_addr_o=req_addr, stable until ack.
  - imem_ack_i is sampled at posedge only while req=1. Ack with req=0 is ignored.
  - Minimum memory latency is 1 cycle. At most one request is outstanding.
- redirect = (branch_i | jump_i) & ~HD_i & ~mem_stall_i.
  - Target = branch_addr_i if branch_i, else jump_addr_i (branch wins when both are asserted).
  - Bits [1:0] of the target are forced to 0.
- consume = (state==HOLD) & ~HD_i & ~mem_stall_i.
- FETCH:
  - ack & ~redirect: ibuf<=imem_data_i, ipc4<=req_addr+4, go to HOLD.
  - ack & redirect: discard data, pc<=req_addr<=target, stay in FETCH (new request next cycle).
  - ~ack & redirect: pc<=target, go to DRAIN.
  - Otherwise stay.
- HOLD:
  - imem_req_o=0, instr_o=ibuf, pc4_o=ipc4, if_stall_o=0.
  - redirect: pc<=req_addr<=target, go to FETCH (redirect has priority over sequential advance).
  - Else consume: pc<=req_addr<=ipc4, go to FETCH.
  - Else hold all values (stall).
- DRAIN:
  - Waits for the ack of the superseded request; the returned data is never shown on instr_o.
  - A further redirect overwrites pc (latest target wins).
  - On ack: req_addr<=pc, go to FETCH.
- Outside HOLD: instr_o=NOP_INSTR, pc4_o=0, if_stall_o=1.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0 without a flag.
- Throughput is one instruction per 2 cycles with a 1-cycle-ack memory. This is accepted; there is no bypass from ack to outputs.

Test Plan:
- Reset then 1-cycle-ack memory, no stalls:
  - Requests at 0, 4, 8 on cycles 1, 3, 5.
  - instr_o matches memory; pc4_o = 4, 8, 12.
  - if_stall_o alternates 1/0.
- HD_i=1 for 3 cycles while in HOLD at address 8:
  - instr_o/pc4_o hold at mem[8]/12; imem_req_o stays 0.
  - After release the next request goes to 12.
- branch_i=1, branch_addr_i=0x40 while in HOLD:
  - Next request is address 0x40; pc4_o then shows 0x44.
  - Repeat with mem_stall_i=1: branch ignored until the stall drops.
- Redirect to 0x80 during a 4-cycle-latency fetch of 0x10 (DRAIN):
  - req stays at 0x10 until ack; its data never appears.
  - The following request is 0x80.
  - Second redirect to 0xC0 during DRAIN: the following request is 0xC0.
- branch_i and jump_i together (0x20 vs 0x30): fetch goes to 0x20.
- Async reset asserted mid-FETCH between clock edges: outputs go to reset values immediately.
- Start at pc=0xFFFF_FFFC: pc4_o=0, next request address is 0.
